stack_controller: RTL and testbench

Sequencing front end for the 64-entry register stack: accepts stack-machine instructions over a valid/ready handshake and turns each into one or more `stackOP`/`w` commands. Drives those commands on the rising edge; the stack applies them on the following falling edge. Reads the top two entries (`a`, `b`) back from the stack to compute ALU results and duplicated values. Tracks stack depth and, when configured, blocks underflow and overflow.

---
 rtl/stack_controller.sv | 260 ++++++++++++++++++++++++++
 tb/tb_stack_controller.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_controller.sv
// Instruction sequencer for the 64-entry register stack: turns stack-machine opcodes into stackOP/w commands.
// Define STACK_CTL_CHECK_EN to block underflow/overflow and raise the sticky err_under/err_over flags.
module stack_controller #(
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [3:0]  instr_op,
  input  logic [15:0] instr_imm,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [2:0]  stackOP,
  output logic [15:0] w,
  output logic [6:0]  depth,
  output logic        busy,
  output logic        err_under,
  output logic        err_over
);

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_PUSHI = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_SUB   = 4'd3;
  localparam logic [3:0] OP_DROP  = 4'd4;
  localparam logic [3:0] OP_DROP2 = 4'd5;
  localparam logic [3:0] OP_SWAP  = 4'd6;
  localparam logic [3:0] OP_DUP   = 4'd7;
  localparam logic [3:0] OP_OVER  = 4'd8;
  localparam logic [3:0] OP_DUP2  = 4'd9;
  localparam logic [3:0] OP_ROT   = 4'd10;

  localparam logic [2:0] CMD_NONE = 3'd0;
  localparam logic [2:0] CMD_PUSH = 3'd1;
  localparam logic [2:0] CMD_REPL = 3'd2;
  localparam logic [2:0] CMD_POP  = 3'd3;
  localparam logic [2:0] CMD_POP2 = 3'd4;
  localparam logic [2:0] CMD_SWAP = 3'd5;

  localparam logic [6:0] DEPTH_7 = 7'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DUP2_B,
    S_ROT_2,
    S_ROT_3,
    S_ROT_4
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [15:0] w_q, w_d;
  logic [6:0]  depth_q, depth_d;
  logic [15:0] t_q, t_d;

  // First-cycle decode of the presented instruction
  logic [2:0]  dec_cmd;
  logic [15:0] dec_w;
  logic [6:0]  dec_depth;
  state_t      dec_next;
  logic        dec_capture;

  function automatic logic [6:0] depth_inc(input logic [6:0] d);
    return (d >= DEPTH_7) ? DEPTH_7 : d + 7'd1;
  endfunction

  function automatic logic [6:0] depth_dec(input logic [6:0] d);
    return (d == 7'd0) ? 7'd0 : d - 7'd1;
  endfunction

  always_comb begin
    dec_cmd     = CMD_NONE;
    dec_w       = w_q;
    dec_depth   = depth_q;
    dec_next    = S_IDLE;
    dec_capture = 1'b0;
    case (instr_op)
      OP_PUSHI: begin
        dec_cmd   = CMD_PUSH;
        dec_w     = instr_imm;
        dec_depth = depth_inc(depth_q);
      end
      OP_ADD: begin
        dec_cmd   = CMD_REPL;
        dec_w     = b + a;
        dec_depth = depth_dec(depth_q);
      end
      OP_SUB: begin
        dec_cmd   = CMD_REPL;
        dec_w     = b - a;
        dec_depth = depth_dec(depth_q);
      end
      OP_DROP: begin
        dec_cmd   = CMD_POP;
        dec_depth = depth_dec(depth_q);
      end
      OP_DROP2: begin
        dec_cmd   = CMD_POP2;
        dec_depth = depth_dec(depth_dec(depth_q));
      end
      OP_SWAP: dec_cmd = CMD_SWAP;
      OP_DUP: begin
        dec_cmd   = CMD_PUSH;
        dec_w     = a;
        dec_depth = depth_inc(depth_q);
      end
      OP_OVER: begin
        dec_cmd   = CMD_PUSH;
        dec_w     = b;
        dec_depth = depth_inc(depth_q);
      end
      OP_DUP2: begin
        dec_cmd   = CMD_PUSH;
        dec_w     = b;
        dec_depth = depth_inc(depth_q);
        dec_next  = S_DUP2_B;
      end
      OP_ROT: begin
        dec_cmd     = CMD_POP;
        dec_depth   = depth_dec(depth_q);
        dec_next    = S_ROT_2;
        dec_capture = 1'b1;
      end
      default: dec_cmd = CMD_NONE;
    endcase
  end

`ifdef STACK_CTL_CHECK_EN
  logic [2:0] need_min;
  logic [1:0] need_room;
  logic       chk_under;
  logic       chk_over;
  logic       err_under_q, err_under_d;
  logic       err_over_q, err_over_d;

  // Whole-instruction depth requirement, checked once at acceptance
  always_comb begin
    need_min  = 3'd0;
    need_room = 2'd0;
    case (instr_op)
      OP_PUSHI: need_room = 2'd1;
      OP_ADD, OP_SUB, OP_DROP2, OP_SWAP: need_min = 3'd2;
      OP_DROP: need_min = 3'd1;
      OP_DUP: begin
        need_min  = 3'd1;
        need_room = 2'd1;
      end
      OP_OVER: begin
        need_min  = 3'd2;
        need_room = 2'd1;
      end
      OP_DUP2: begin
        need_min  = 3'd2;
        need_room = 2'd2;
      end
      OP_ROT: need_min = 3'd3;
      default: need_min = 3'd0;
    endcase
  end

  assign chk_under = depth_q < {4'd0, need_min};
  assign chk_over  = ({1'b0, depth_q} + {6'd0, need_room}) > {1'b0, DEPTH_7};
`endif

  always_comb begin
    state_d = state_q;
    op_d    = CMD_NONE;
    w_d     = w_q;
    depth_d = depth_q;
    t_d     = t_q;
`ifdef STACK_CTL_CHECK_EN
    err_under_d = err_under_q;
    err_over_d  = err_over_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
`ifdef STACK_CTL_CHECK_EN
          if (chk_under) begin
            err_under_d = 1'b1;
          end else if (chk_over) begin
            err_over_d = 1'b1;
          end else
`endif
          begin
            op_d    = dec_cmd;
            w_d     = dec_w;
            depth_d = dec_depth;
            state_d = dec_next;
            if (dec_capture) t_d = a;
          end
        end
      end
      S_DUP2_B: begin
        // After the first push the original top has moved down into b
        op_d    = CMD_PUSH;
        w_d     = b;
        depth_d = depth_inc(depth_q);
        state_d = S_IDLE;
      end
      S_ROT_2: begin
        op_d    = CMD_SWAP;
        state_d = S_ROT_3;
      end
      S_ROT_3: begin
        op_d    = CMD_PUSH;
        w_d     = t_q;
        depth_d = depth_inc(depth_q);
        state_d = S_ROT_4;
      end
      S_ROT_4: begin
        op_d    = CMD_SWAP;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= CMD_NONE;
      w_q     <= 16'd0;
      depth_q <= 7'd0;
      t_q     <= 16'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      w_q     <= w_d;
      depth_q <= depth_d;
      t_q     <= t_d;
    end
  end

`ifdef STACK_CTL_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      err_under_q <= 1'b0;
      err_over_q  <= 1'b0;
    end else begin
      err_under_q <= err_under_d;
      err_over_q  <= err_over_d;
    end
  end

  assign err_under = err_under_q;
  assign err_over  = err_over_q;
`else
  assign err_under = 1'b0;
  assign err_over  = 1'b0;
`endif

  assign instr_ready = (state_q == S_IDLE);
  assign busy        = ~instr_ready;
  assign stackOP     = op_q;
  assign w           = w_q;
  assign depth       = depth_q;

endmodule

// File: tb/tb_stack_controller.sv
// Bench for stack_controller: a behavioural 64-entry stack closes the loop on a/b, and a
// scoreboard queue of hand-computed commands is checked by a monitor forked off the main thread.
module tb_stack_controller;

  logic        clk;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  instr_op;
  logic [15:0] instr_imm;
  logic [15:0] a_m;
  logic [15:0] b_m;
  logic [2:0]  stackOP;
  logic [15:0] w;
  logic [6:0]  depth;
  logic        busy;
  logic        err_under;
  logic        err_over;

  stack_controller #(.DEPTH(64)) dut (
    .clk(clk),
    .reset(reset),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr_op(instr_op),
    .instr_imm(instr_imm),
    .a(a_m),
    .b(b_m),
    .stackOP(stackOP),
    .w(w),
    .depth(depth),
    .busy(busy),
    .err_under(err_under),
    .err_over(err_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural register stack: applies commands on the falling edge, cleared by the shared reset
  logic [15:0] mem [0:63];
  int          sp = 0;
  logic        rst_seen = 1'b0;

  always @(posedge clk) rst_seen <= reset;

  always @(negedge clk) begin
    if (rst_seen) begin
      sp <= 0;
      for (int i = 0; i < 64; i++) mem[i] <= 16'h0;
    end else begin
      case (stackOP)
        3'd1: if (sp < 64) begin
          mem[6'(sp)] <= w;
          sp <= sp + 1;
        end
        3'd2: if (sp >= 2) begin
          mem[6'(sp - 2)] <= w;
          sp <= sp - 1;
        end
        3'd3: if (sp >= 1) sp <= sp - 1;
        3'd4: sp <= (sp >= 2) ? sp - 2 : 0;
        3'd5: if (sp >= 2) begin
          mem[6'(sp - 1)] <= mem[6'(sp - 2)];
          mem[6'(sp - 2)] <= mem[6'(sp - 1)];
        end
        default: ;
      endcase
    end
  end

  assign a_m = (sp >= 1) ? mem[6'(sp - 1)] : 16'h0;
  assign b_m = (sp >= 2) ? mem[6'(sp - 2)] : 16'h0;

  typedef struct packed {
    logic [2:0]  op;
    logic [15:0] wv;
    logic [6:0]  dep;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic expect_cmd(input logic [2:0] op, input logic [15:0] wv, input logic [6:0] dep);
    exp_t e;
    e.op  = op;
    e.wv  = wv;
    e.dep = dep;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end else begin
      $display("check %s = %0h", name, act);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [15:0] imm);
    int guard;
    guard       = 0;
    instr_valid = 1'b1;
    instr_op    = op;
    instr_imm   = imm;
    while (!instr_ready && guard < 20) begin
      @(posedge clk);
      #2;
      guard++;
    end
    if (!instr_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL issue_timeout op=%0d actual ready=0 required ready=1", op);
    end
    @(posedge clk);
    #2;
    instr_valid = 1'b0;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    instr_valid = 1'b0;
    instr_op    = 4'd0;
    instr_imm   = 16'd0;

    fork
      forever begin
        @(posedge clk);
        #1;
        if (stackOP != 3'd0) begin
          n_vec++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_cmd actual op=%0d w=%h required no command", stackOP, w);
          end else begin
            mon_e = exp_q.pop_front();
            if (stackOP !== mon_e.op || w !== mon_e.wv || depth !== mon_e.dep) begin
              n_err++;
              $display("FAIL cmd actual op=%0d w=%h depth=%0d required op=%0d w=%h depth=%0d",
                       stackOP, w, depth, mon_e.op, mon_e.wv, mon_e.dep);
            end else begin
              $display("cmd op=%0d w=%h depth=%0d", stackOP, w, depth);
            end
          end
        end
      end
      begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
      end
    join_none

    do_reset();
    chk("rst_ready", instr_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_stackOP", stackOP, 0);
    chk("rst_w", w, 0);
    chk("rst_depth", depth, 0);
    chk("rst_err_under", err_under, 0);
    chk("rst_err_over", err_over, 0);

    // Back-to-back ADD
    expect_cmd(3'd1, 16'd5, 7'd1);  issue(4'd1, 16'd5);
    expect_cmd(3'd1, 16'd7, 7'd2);  issue(4'd1, 16'd7);
    expect_cmd(3'd2, 16'd12, 7'd1); issue(4'd2, 16'd0);
    settle();
    chk("add_a", a_m, 16'd12);
    chk("add_depth", depth, 1);
    expect_cmd(3'd3, 16'd12, 7'd0); issue(4'd4, 16'd0);

    // SUB, wrapping and non-wrapping
    expect_cmd(3'd1, 16'd3, 7'd1);       issue(4'd1, 16'd3);
    expect_cmd(3'd1, 16'd10, 7'd2);      issue(4'd1, 16'd10);
    expect_cmd(3'd2, 16'hFFF9, 7'd1);    issue(4'd3, 16'd0);
    settle();
    chk("sub_wrap_a", a_m, 16'hFFF9);
    expect_cmd(3'd3, 16'hFFF9, 7'd0);    issue(4'd4, 16'd0);
    expect_cmd(3'd1, 16'd10, 7'd1);      issue(4'd1, 16'd10);
    expect_cmd(3'd1, 16'd3, 7'd2);       issue(4'd1, 16'd3);
    expect_cmd(3'd2, 16'd7, 7'd1);       issue(4'd3, 16'd0);
    settle();
    chk("sub_a", a_m, 16'd7);
    expect_cmd(3'd3, 16'd7, 7'd0);       issue(4'd4, 16'd0);

    // ROT: 1 2 3 -> 2 3 1
    expect_cmd(3'd1, 16'd1, 7'd1); issue(4'd1, 16'd1);
    expect_cmd(3'd1, 16'd2, 7'd2); issue(4'd1, 16'd2);
    expect_cmd(3'd1, 16'd3, 7'd3); issue(4'd1, 16'd3);
    expect_cmd(3'd3, 16'd3, 7'd2);
    expect_cmd(3'd5, 16'd3, 7'd2);
    expect_cmd(3'd1, 16'd3, 7'd3);
    expect_cmd(3'd5, 16'd3, 7'd3);
    issue(4'd10, 16'd0);
    chk("rot_ready_c1", instr_ready, 0);
    @(posedge clk); #2;
    chk("rot_ready_c2", instr_ready, 0);
    @(posedge clk); #2;
    chk("rot_ready_c3", instr_ready, 0);
    @(posedge clk); #2;
    chk("rot_ready_back", instr_ready, 1);
    settle();
    chk("rot_a", a_m, 16'd1);
    chk("rot_b", b_m, 16'd3);
    chk("rot_depth", depth, 3);
    expect_cmd(3'd4, 16'd3, 7'd1); issue(4'd5, 16'd0);
    expect_cmd(3'd3, 16'd3, 7'd0); issue(4'd4, 16'd0);

    // DUP2: 4 9 -> 4 9 4 9
    expect_cmd(3'd1, 16'd4, 7'd1); issue(4'd1, 16'd4);
    expect_cmd(3'd1, 16'd9, 7'd2); issue(4'd1, 16'd9);
    expect_cmd(3'd1, 16'd4, 7'd3);
    expect_cmd(3'd1, 16'd9, 7'd4);
    issue(4'd9, 16'd0);
    chk("dup2_busy_c1", busy, 1);
    @(posedge clk); #2;
    chk("dup2_busy_done", busy, 0);
    settle();
    chk("dup2_a", a_m, 16'd9);
    chk("dup2_b", b_m, 16'd4);
    chk("dup2_depth", depth, 4);
    expect_cmd(3'd4, 16'd9, 7'd2); issue(4'd5, 16'd0);
    expect_cmd(3'd4, 16'd9, 7'd0); issue(4'd5, 16'd0);

    // Reset during ROT cycle 2, with an instruction presented alongside reset
    expect_cmd(3'd1, 16'd1, 7'd1); issue(4'd1, 16'd1);
    expect_cmd(3'd1, 16'd2, 7'd2); issue(4'd1, 16'd2);
    expect_cmd(3'd1, 16'd3, 7'd3); issue(4'd1, 16'd3);
    expect_cmd(3'd3, 16'd3, 7'd2); issue(4'd10, 16'd0);
    reset       = 1'b1;
    instr_valid = 1'b1;
    instr_op    = 4'd1;
    instr_imm   = 16'h0099;
    @(posedge clk); #2;
    chk("rotrst_ready", instr_ready, 1);
    chk("rotrst_depth", depth, 0);
    chk("rotrst_stackOP", stackOP, 0);
    settle();
    chk("rotrst_a", a_m, 16'd0);
    instr_valid = 1'b0;
    reset       = 1'b0;
    @(posedge clk); #2;

    // DROP on an empty stack
`ifdef STACK_CTL_CHECK_EN
    issue(4'd4, 16'd0);
    chk("under_stackOP", stackOP, 0);
    chk("under_err_under", err_under, 1);
`else
    expect_cmd(3'd3, 16'd0, 7'd0); issue(4'd4, 16'd0);
    chk("under_stackOP", stackOP, 3);
    chk("under_err_under", err_under, 0);
`endif
    chk("under_depth", depth, 0);

    // Fill to capacity, then one more
    for (int i = 0; i < 64; i++) begin
      expect_cmd(3'd1, 16'(i + 100), 7'(i + 1));
      issue(4'd1, 16'(i + 100));
    end
    chk("full_depth", depth, 64);
`ifdef STACK_CTL_CHECK_EN
    issue(4'd1, 16'hBEEF);
    chk("over_stackOP", stackOP, 0);
    chk("over_err_over", err_over, 1);
`else
    expect_cmd(3'd1, 16'hBEEF, 7'd64); issue(4'd1, 16'hBEEF);
    chk("over_stackOP", stackOP, 1);
    chk("over_err_over", err_over, 0);
`endif
    chk("over_depth", depth, 64);

    // DUP, OVER, SWAP and NOP-class opcodes back to back
    do_reset();
    chk("rst2_err_over", err_over, 0);
    expect_cmd(3'd1, 16'h1234, 7'd1); issue(4'd1, 16'h1234);
    expect_cmd(3'd1, 16'h1234, 7'd2); issue(4'd7, 16'd0);
    expect_cmd(3'd1, 16'h0055, 7'd3); issue(4'd1, 16'h0055);
    expect_cmd(3'd1, 16'h1234, 7'd4); issue(4'd8, 16'd0);
    expect_cmd(3'd5, 16'h1234, 7'd4); issue(4'd6, 16'd0);
    issue(4'd0, 16'hAAAA);
    issue(4'd12, 16'hBBBB);
    settle();
    chk("mix_a", a_m, 16'h0055);
    chk("mix_b", b_m, 16'h1234);
    chk("mix_depth", depth, 4);
    chk("mix_w_held", w, 16'h1234);

    repeat (3) @(posedge clk);
    #2;
    chk("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
